drm_tag_ctrl: RTL and testbench

DRM_TAG_CTRL -- requirements
Module: drm_tag_ctrl

---
 rtl/drm_tag_pkg.sv | 32 +++
 rtl/drm_tag.sv | 32 +++
 rtl/drm_tag_ctrl.sv | 145 ++++++++++++++
 tb/tb_drm_tag_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/drm_tag_pkg.sv
// Shared definitions for the tag controller and its tag RAM.
//   IDX_W/TAG_W/ENTRY_W : index, tag and stored-entry widths
//   VALID_BIT, TAG_MSB/TAG_LSB : field positions inside a stored entry
//   state_e : controller FSM encoding
//   lk_pipe_t : lookup state carried across the RAM read stage
package drm_tag_pkg;

  localparam int IDX_W     = 6;
  localparam int TAG_W     = 7;
  localparam int ENTRY_W   = 8;
  localparam int DEPTH     = 1 << IDX_W;
  localparam int VALID_BIT = 7;
  localparam int TAG_MSB   = 6;
  localparam int TAG_LSB   = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
  } lk_pipe_t;

  // A freshly installed entry is always valid.
  function automatic logic [ENTRY_W-1:0] mk_entry(input logic [TAG_W-1:0] tag);
    return {1'b1, tag};
  endfunction

endpackage

// File: rtl/drm_tag.sv
// 64x8 simple dual-port tag RAM, one write port and one read port, both on clk.
// Read data is registered (1-cycle latency).
//   wr_rst/wr_en/wr_be/wr_addr/wr_data : write port (wr_rst suppresses writes)
//   rd_rst/rd_en/rd_addr/rd_data       : read port (rd_rst clears the output register)
module drm_tag
  import drm_tag_pkg::*;
(
  input  logic               clk,
  input  logic               wr_rst,
  input  logic               wr_en,
  input  logic               wr_be,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               rd_rst,
  input  logic               rd_en,
  input  logic [IDX_W-1:0]   rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Array contents are not reset; the controller sweeps them clear instead.
  always_ff @(posedge clk) begin
    if (!wr_rst && wr_en && wr_be) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_rst)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/drm_tag_ctrl.sv
// Tag lookup/fill controller in front of a 64-entry tag RAM.
//   clk, rst              : clock, synchronous active-high reset
//   lk_valid/lk_ready     : lookup handshake, lk_index/lk_tag payload
//   fl_valid/fl_ready     : fill handshake, fl_index/fl_tag payload
//   inv_all               : invalidate-all pulse (starts a clear sweep)
//   rsp_valid/hit/index   : lookup result, one cycle after acceptance
//   busy                  : clear sweep in progress
//   hit_cnt/miss_cnt      : saturating response counters
module drm_tag_ctrl
  import drm_tag_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               lk_valid,
  output logic               lk_ready,
  input  logic [IDX_W-1:0]   lk_index,
  input  logic [TAG_W-1:0]   lk_tag,
  input  logic               fl_valid,
  output logic               fl_ready,
  input  logic [IDX_W-1:0]   fl_index,
  input  logic [TAG_W-1:0]   fl_tag,
  input  logic               inv_all,
  output logic               rsp_valid,
  output logic               rsp_hit,
  output logic [IDX_W-1:0]   rsp_index,
  output logic               busy,
  output logic [15:0]        hit_cnt,
  output logic [15:0]        miss_cnt
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sweep_q, sweep_d;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_addr;
  logic [ENTRY_W-1:0] wr_data;
  logic               lk_acc;
  logic [ENTRY_W-1:0] rd_data;
  lk_pipe_t           pipe_q;
  logic [15:0]        hit_q, miss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    lk_ready = 1'b0;
    fl_ready = 1'b0;
    busy     = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = sweep_q;
    wr_data  = '0;
    unique case (state_q)
      CLEAR: begin
        wr_en = 1'b1;
        if (inv_all) begin
          sweep_d = '0;
        end else if (&sweep_q) begin
          state_d = RUN;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      RUN: begin
        busy     = 1'b0;
        fl_ready = !inv_all;
        // Lookups yield to fills, so the read and write ports never collide.
        lk_ready = !inv_all && !fl_valid;
        if (inv_all) begin
          state_d = CLEAR;
          sweep_d = '0;
        end else if (fl_valid) begin
          wr_en   = 1'b1;
          wr_addr = fl_index;
          wr_data = mk_entry(fl_tag);
        end
      end
      default: ;
    endcase
    if (rst) begin
      lk_ready = 1'b0;
      fl_ready = 1'b0;
      busy     = 1'b1;
      wr_en    = 1'b0;
    end
  end

  assign lk_acc = lk_valid && lk_ready;

  drm_tag u_tag (
    .clk     (clk),
    .wr_rst  (rst),
    .wr_en   (wr_en),
    .wr_be   (1'b1),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_rst  (rst),
    .rd_en   (lk_acc),
    .rd_addr (lk_index),
    .rd_data (rd_data)
  );

  // Lookup context travels alongside the RAM read so the compare lines up with rd_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q.vld <= lk_acc;
      if (lk_acc) begin
        pipe_q.idx <= lk_index;
        pipe_q.tag <= lk_tag;
      end
    end
  end

  // Outputs are masked while rst is high so an in-flight response never escapes.
  assign rsp_valid = pipe_q.vld && !rst;
  assign rsp_hit   = rsp_valid && rd_data[VALID_BIT] && (rd_data[TAG_MSB:TAG_LSB] == pipe_q.tag);
  assign rsp_index = rst ? '0 : pipe_q.idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (rsp_valid) begin
      if (rsp_hit) begin
        if (!(&hit_q)) hit_q <= hit_q + 16'd1;
      end else begin
        if (!(&miss_q)) miss_q <= miss_q + 16'd1;
      end
    end
  end

  assign hit_cnt  = rst ? '0 : hit_q;
  assign miss_cnt = rst ? '0 : miss_q;

endmodule

// File: tb/tb_drm_tag_ctrl.sv
module tb_drm_tag_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lk_valid = 1'b0, fl_valid = 1'b0, inv_all = 1'b0;
  logic [5:0]  lk_index = '0, fl_index = '0;
  logic [6:0]  lk_tag = '0, fl_tag = '0;
  logic        lk_ready, fl_ready, rsp_valid, rsp_hit, busy;
  logic [5:0]  rsp_index;
  logic [15:0] hit_cnt, miss_cnt;

  drm_tag_ctrl dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_index(lk_index), .lk_tag(lk_tag),
    .fl_valid(fl_valid), .fl_ready(fl_ready), .fl_index(fl_index), .fl_tag(fl_tag),
    .inv_all(inv_all),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_index(rsp_index),
    .busy(busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] idx;
    logic       hit;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] model [64];
  int         checks = 0, errors = 0, cyc = 0;
  int         exp_hit = 0, exp_miss = 0;
  int         n;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Response monitor: every rsp_valid must match the oldest accepted lookup.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      chk("rsp_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("rsp_index", 32'(rsp_index), 32'(mon_e.idx));
        chk("rsp_hit", 32'(rsp_hit), 32'(mon_e.hit));
        chk("rsp_latency", 32'(cyc - mon_e.cyc), 1);
        if (mon_e.hit) begin
          if (exp_hit < 65535) exp_hit++;
        end else begin
          if (exp_miss < 65535) exp_miss++;
        end
      end
    end
  end

  // One cycle: record what the DUT accepts at the coming edge, then advance.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (lk_valid && lk_ready) begin
      e.idx = lk_index;
      e.hit = model[lk_index][7] && (model[lk_index][6:0] == lk_tag);
      e.cyc = cyc;
      sb.push_back(e);
    end
    if (fl_valid && fl_ready) model[fl_index] = {1'b1, fl_tag};
    if (inv_all) for (int i = 0; i < 64; i++) model[i] = 8'h00;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) tick();
  endtask

  task automatic lookup(input int idx, input int tag);
    lk_valid = 1'b1; lk_index = 6'(idx); lk_tag = 7'(tag);
    tick();
    lk_valid = 1'b0;
  endtask

  task automatic fill(input int idx, input int tag);
    fl_valid = 1'b1; fl_index = 6'(idx); fl_tag = 7'(tag);
    tick();
    fl_valid = 1'b0;
  endtask

  task automatic pulse_inv();
    inv_all = 1'b1;
    #1;
    chk("lk_ready_inv", 32'(lk_ready), 0);
    chk("fl_ready_inv", 32'(fl_ready), 0);
    tick();
    inv_all = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    exp_hit = 0;
    exp_miss = 0;
    for (int i = 0; i < 64; i++) model[i] = 8'h00;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_hit", 32'(rsp_hit), 0);
    chk("rst_rsp_index", 32'(rsp_index), 0);
    chk("rst_lk_ready", 32'(lk_ready), 0);
    chk("rst_fl_ready", 32'(fl_ready), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_hit_cnt", 32'(hit_cnt), 0);
    chk("rst_miss_cnt", 32'(miss_cnt), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Counts busy cycles until the sweep ends; a bound keeps a stuck sweep from hanging.
  task automatic wait_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      else break;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset and initial sweep
    do_reset();
    wait_busy(n);
    chk("init_busy_cycles", 32'(n), 64);
    chk("run_lk_ready", 32'(lk_ready), 1);
    chk("run_fl_ready", 32'(fl_ready), 1);

    // Lookup of a cleared entry misses
    lookup(63, 0);
    idle(2);
    chk("miss_cnt_first", 32'(miss_cnt), 1);
    chk("hit_cnt_first", 32'(hit_cnt), 32'(exp_hit));

    // Fill then lookup on the next cycle hits
    fill(5, 7'h2A);
    lookup(5, 7'h2A);
    idle(2);
    chk("hit_cnt_fill", 32'(hit_cnt), 1);

    // Fill and lookup together: fill wins, lookup follows and hits
    fl_valid = 1'b1; fl_index = 6'd20; fl_tag = 7'h33;
    lk_valid = 1'b1; lk_index = 6'd20; lk_tag = 7'h33;
    #1;
    chk("both_fl_ready", 32'(fl_ready), 1);
    chk("both_lk_ready", 32'(lk_ready), 0);
    tick();
    fl_valid = 1'b0;
    #1;
    chk("after_lk_ready", 32'(lk_ready), 1);
    tick();
    lk_valid = 1'b0;
    idle(2);
    chk("hit_cnt_both", 32'(hit_cnt), 32'(exp_hit));

    // Lookup followed by a fill to the same index returns the old entry
    lookup(20, 7'h44);
    fill(20, 7'h44);
    lookup(20, 7'h44);
    idle(2);
    chk("hit_cnt_order", 32'(hit_cnt), 32'(exp_hit));
    chk("miss_cnt_order", 32'(miss_cnt), 32'(exp_miss));

    // Invalidate-all: lookup before the pulse still responds, entry is gone after
    fill(10, 7'h11);
    lookup(10, 7'h11);
    pulse_inv();
    wait_busy(n);
    chk("inv_busy_cycles", 32'(n), 64);
    lookup(10, 7'h11);
    idle(2);
    chk("hit_cnt_inv", 32'(hit_cnt), 32'(exp_hit));
    chk("miss_cnt_inv", 32'(miss_cnt), 32'(exp_miss));
    chk("sb_empty_inv", 32'(sb.size()), 0);

    // inv_all mid-sweep restarts the sweep
    pulse_inv();
    idle(10);
    pulse_inv();
    wait_busy(n);
    chk("restart_busy_cycles", 32'(n), 64);

    // Reset with a lookup in flight discards the response
    lookup(3, 0);
    do_reset();
    wait_busy(n);
    chk("rst_lookup_busy", 32'(n), 64);
    chk("hit_cnt_after_rst", 32'(hit_cnt), 0);

    // Reset at sweep address 30
    pulse_inv();
    idle(30);
    do_reset();
    wait_busy(n);
    chk("rst_sweep_busy", 32'(n), 64);

    // Miss counter saturation
    lk_valid = 1'b1; lk_index = 6'd0; lk_tag = 7'd0;
    repeat (65537) tick();
    lk_valid = 1'b0;
    idle(3);
    chk("miss_cnt_model", 32'(miss_cnt), 32'(exp_miss));
    chk("miss_cnt_sat", 32'(miss_cnt), 32'hFFFF);
    chk("hit_cnt_sat", 32'(hit_cnt), 0);
    chk("sb_empty_end", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
